// File: rtl/button_debounce_bank.sv
// Multi-channel push-button conditioner: per channel a two-flop synchroniser, symmetric
// debounce, press/release pulses and a once-per-press long-press detector.

module button_debounce_lane #(
   parameter int CNT_WIDTH   = 10,
   parameter int HOLD_CYCLES = 1023,
   parameter int LONG_WIDTH  = 16,
   parameter int LONG_CYCLES = 50000
) (
   input  logic clock,
   input  logic reset,
   input  logic btn,
   output logic level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_press,
   output logic long_held
);
   localparam logic [CNT_WIDTH-1:0]  HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [LONG_WIDTH-1:0] LONG_SAT  = LONG_WIDTH'(LONG_CYCLES);
   localparam logic [LONG_WIDTH-1:0] LONG_LAST = LONG_WIDTH'(LONG_CYCLES - 1);
   localparam logic [LONG_WIDTH-1:0] LONG_ONE  = LONG_WIDTH'(1);

   logic                  s1;
   logic                  sync_q;
   logic [CNT_WIDTH-1:0]  cnt;
   logic [LONG_WIDTH-1:0] lcnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1     <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         s1     <= btn;
         sync_q <= s1;
      end
   end

   // Any sample agreeing with the accepted level restarts the stability count.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         level         <= 1'b0;
         cnt           <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         if (sync_q == level) begin
            cnt <= '0;
         end else if (cnt == HOLD_LAST) begin
            level         <= sync_q;
            cnt           <= '0;
            press_pulse   <= sync_q;
            release_pulse <= ~sync_q;
         end else begin
            cnt <= cnt + CNT_ONE;
         end
      end
   end

   // Long-press counter saturates at LONG_CYCLES so it fires once per press.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lcnt       <= '0;
         long_press <= 1'b0;
         long_held  <= 1'b0;
      end else begin
         long_press <= 1'b0;
         if (!level) begin
            lcnt      <= '0;
            long_held <= 1'b0;
         end else if (lcnt < LONG_SAT) begin
            lcnt <= lcnt + LONG_ONE;
            if (lcnt == LONG_LAST) begin
               long_press <= 1'b1;
               long_held  <= 1'b1;
            end
         end
      end
   end
endmodule

module button_debounce_bank #(
   parameter int CHANNELS    = 2,
   parameter int CNT_WIDTH   = 10,
   parameter int HOLD_CYCLES = 1023,
   parameter int LONG_WIDTH  = 16,
   parameter int LONG_CYCLES = 50000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [CHANNELS-1:0] btn_in,
   output logic [CHANNELS-1:0] level_out,
   output logic [CHANNELS-1:0] press_pulse,
   output logic [CHANNELS-1:0] release_pulse,
   output logic [CHANNELS-1:0] long_press,
   output logic [CHANNELS-1:0] long_held
);
   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      button_debounce_lane #(
         .CNT_WIDTH  (CNT_WIDTH),
         .HOLD_CYCLES(HOLD_CYCLES),
         .LONG_WIDTH (LONG_WIDTH),
         .LONG_CYCLES(LONG_CYCLES)
      ) u_lane (
         .clock        (clock),
         .reset        (reset),
         .btn          (btn_in[g]),
         .level        (level_out[g]),
         .press_pulse  (press_pulse[g]),
         .release_pulse(release_pulse[g]),
         .long_press   (long_press[g]),
         .long_held    (long_held[g])
      );
   end
endmodule

// File: tb/tb_button_debounce_bank.sv
// Bench for button_debounce_bank: expected per-cycle output vectors are derived from
// press/release timing and queued before stimulus, then popped each cycle.

module tb_button_debounce_bank;
   localparam int NEVER = 1000000;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] btn_in = '0;
   logic [1:0] level_out, press_pulse, release_pulse, long_press, long_held;
   logic [0:0] btn1 = '0;
   logic [0:0] lvl1, pp1, rp1, lp1, lh1;

   int n_checks = 0;
   int n_fail   = 0;
   logic [9:0] exp_q[$];

   always #5 clock = ~clock;

   button_debounce_bank #(.CHANNELS(2), .CNT_WIDTH(4), .HOLD_CYCLES(4),
                          .LONG_WIDTH(8), .LONG_CYCLES(10)) dut (
      .clock(clock), .reset(reset), .btn_in(btn_in), .level_out(level_out),
      .press_pulse(press_pulse), .release_pulse(release_pulse),
      .long_press(long_press), .long_held(long_held));

   button_debounce_bank #(.CHANNELS(1), .CNT_WIDTH(1), .HOLD_CYCLES(1),
                          .LONG_WIDTH(4), .LONG_CYCLES(3)) dut1 (
      .clock(clock), .reset(reset), .btn_in(btn1), .level_out(lvl1),
      .press_pulse(pp1), .release_pulse(rp1), .long_press(lp1), .long_held(lh1));

   // Expected {long_held, long_press, release_pulse, press_pulse, level} at relative
   // cycle e for a press whose level rises at r and falls at f, long threshold l.
   function automatic logic [4:0] exp_ch(int e, int r, int f, int l);
      logic lng;
      lng = (f >= r + l);
      return {lng && e >= r + l && e <= f, lng && e == r + l, e == f, e == r, e >= r && e < f};
   endfunction

   function automatic logic [9:0] obs_main();
      return {long_held[1], long_press[1], release_pulse[1], press_pulse[1], level_out[1],
              long_held[0], long_press[0], release_pulse[0], press_pulse[0], level_out[0]};
   endfunction

   task automatic do_reset();
      reset  = 1'b1;
      btn_in = '0;
      btn1   = '0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [9:0] exp, obs;
      do_reset();
      btn_in = 2'b11;
      for (int e = 1; e <= 12; e++) exp_q.push_back({exp_ch(e, 6, NEVER, 10), exp_ch(e, 6, NEVER, 10)});
      for (int i = 1; i <= 12; i++) begin
         @(negedge clock);
         exp = exp_q.pop_front(); obs = obs_main(); n_checks++;
         if (obs !== exp) begin n_fail++; $display("FAIL reset_pre cyc %0d: got %b expected %b", i, obs, exp); end
      end
      // Mid-cycle assertion: outputs must clear before the next clock edge.
      @(posedge clock);
      #2 reset = 1'b1;
      exp_q.push_back('0);
      #1;
      exp = exp_q.pop_front(); obs = obs_main(); n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL reset_async: got %b expected %b", obs, exp); end
      @(negedge clock);
      reset = 1'b0;
      for (int e = 1; e <= 8; e++) exp_q.push_back({exp_ch(e, 6, NEVER, 10), exp_ch(e, 6, NEVER, 10)});
      for (int i = 1; i <= 8; i++) begin
         @(negedge clock);
         exp = exp_q.pop_front(); obs = obs_main(); n_checks++;
         if (obs !== exp) begin n_fail++; $display("FAIL reset_post cyc %0d: got %b expected %b", i, obs, exp); end
      end
   endtask

   task automatic test_press_release();
      logic [9:0] exp, obs;
      do_reset();
      for (int e = 1; e <= 32; e++) exp_q.push_back({exp_ch(e, NEVER, NEVER, 10), exp_ch(e, 6, 26, 10)});
      btn_in = 2'b01;
      for (int i = 1; i <= 32; i++) begin
         @(negedge clock);
         exp = exp_q.pop_front(); obs = obs_main(); n_checks++;
         if (obs !== exp) begin n_fail++; $display("FAIL press_release cyc %0d: got %b expected %b", i, obs, exp); end
         if (i == 20) btn_in[0] = 1'b0;
      end
   endtask

   task automatic test_bounce();
      logic [9:0] exp, obs;
      do_reset();
      for (int e = 1; e <= 50; e++) exp_q.push_back({exp_ch(e, NEVER, NEVER, 10), exp_ch(e, 38, 46, 10)});
      btn_in[0] = 1'b1;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clock);
         exp = exp_q.pop_front(); obs = obs_main(); n_checks++;
         if (obs !== exp) begin n_fail++; $display("FAIL bounce cyc %0d: got %b expected %b", i, obs, exp); end
         if (i <= 31) btn_in[0] = (i % 4 != 3);
         else if (i == 32) btn_in[0] = 1'b1;
         else if (i == 40) btn_in[0] = 1'b0;
      end
   endtask

   // Release well after, well before, and on the very edge of the long-press threshold.
   task automatic test_long_press();
      logic [9:0] exp, obs;
      int rel_a;
      for (int k = 0; k < 3; k++) begin
         rel_a = (k == 0) ? 30 : (k == 1) ? 8 : 10;
         do_reset();
         for (int e = 1; e <= rel_a + 12; e++)
            exp_q.push_back({exp_ch(e, 6, rel_a + 6, 10), exp_ch(e, NEVER, NEVER, 10)});
         btn_in = 2'b10;
         for (int i = 1; i <= rel_a + 12; i++) begin
            @(negedge clock);
            exp = exp_q.pop_front(); obs = obs_main(); n_checks++;
            if (obs !== exp) begin
               n_fail++;
               $display("FAIL long_press rel %0d cyc %0d: got %b expected %b", rel_a, i, obs, exp);
            end
            if (i == rel_a) btn_in[1] = 1'b0;
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [9:0] exp, obs;
      do_reset();
      for (int e = 1; e <= 32; e++) exp_q.push_back({exp_ch(e, 6, 14, 10), exp_ch(e, 14, 26, 10)});
      btn_in = 2'b10;
      for (int i = 1; i <= 32; i++) begin
         @(negedge clock);
         exp = exp_q.pop_front(); obs = obs_main(); n_checks++;
         if (obs !== exp) begin n_fail++; $display("FAIL simultaneous cyc %0d: got %b expected %b", i, obs, exp); end
         if (i == 8) btn_in = 2'b01;
         else if (i == 20) btn_in = 2'b00;
      end
   endtask

   task automatic test_hold1();
      logic [9:0] exp, obs;
      do_reset();
      for (int e = 1; e <= 24; e++) exp_q.push_back({5'b0, exp_ch(e, 3, 4, 3) | exp_ch(e, 9, 19, 3)});
      btn1 = 1'b1;
      for (int i = 1; i <= 24; i++) begin
         @(negedge clock);
         exp = exp_q.pop_front(); obs = {5'b0, lh1, lp1, rp1, pp1, lvl1}; n_checks++;
         if (obs !== exp) begin n_fail++; $display("FAIL hold1 cyc %0d: got %b expected %b", i, obs, exp); end
         if (i == 1) btn1 = 1'b0;
         else if (i == 6) btn1 = 1'b1;
         else if (i == 16) btn1 = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_press_release();
      test_bounce();
      test_long_press();
      test_simultaneous();
      test_hold1();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/button_debounce_bank.md
Name: button_debounce_bank

Overview:
- Parametrised multi-channel conditioner for asynchronous push-buttons and switches.
- In the top level it drives start_process, start_transmit and any further operator inputs into main_control.
- Per channel:
  - two-flop synchroniser;
  - symmetric press/release debounce counter;
  - debounced level output;
  - one-cycle press and release pulses;
  - long-press detection.
- Runs on the slowclock-derived system clock.

Parameters:
- CHANNELS, 2, number of independent input channels (>=1).
- CNT_WIDTH, 10, width of each debounce counter.
- HOLD_CYCLES, 1023, consecutive stable cycles needed to accept a change; 1 <= HOLD_CYCLES <= 2^CNT_WIDTH.
- LONG_WIDTH, 16, width of each long-press counter.
- LONG_CYCLES, 50000, cycles of debounced-high before long_press fires; 1 <= LONG_CYCLES < 2^LONG_WIDTH.

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- btn_in  input  CHANNELS  raw asynchronous button levels, 1 = pressed
- level_out  output  CHANNELS  debounced level per channel
- press_pulse  output  CHANNELS  one-cycle pulse, debounced 0->1
- release_pulse  output  CHANNELS  one-cycle pulse, debounced 1->0
- long_press  output  CHANNELS  one-cycle pulse once per press after LONG_CYCLES held
- long_held  output  CHANNELS  level, high from long_press until debounced release

Behaviour:
- Reset state: all registers 0, including synchronisers, counters and every output. Reset mid-count discards progress. After reset deasserts, a held button needs the full latency again.
- Channels are fully independent; no shared state.
- Synchroniser: s1 <= btn_in, then sync_q <= s1.
- Debounce (per channel, state db = level_out, cnt):
  - If sync_q == db: cnt <= 0.
  - Else if cnt == HOLD_CYCLES-1: db <= sync_q; cnt <= 0; press_pulse <= sync_q; release_pulse <= ~sync_q.
  - Else: cnt <= cnt+1.
  - Any cycle with sync_q == db (bounce) restarts the count from 0.
- Latency: btn_in first sampled at the new value at edge E0 and held there → level_out changes at edge E0+1+HOLD_CYCLES. With HOLD_CYCLES=1 that is E0+2.
- Pulse timing: press_pulse and release_pulse are registered. Each is high exactly in the cycle level_out first shows its new value, and 0 otherwise. The two are never both high on one channel.
- Long press (lcnt, using pre-edge db):
  - If db == 0: lcnt <= 0, long_held <= 0.
  - Else if lcnt < LONG_CYCLES: lcnt <= lcnt+1. When lcnt == LONG_CYCLES-1: long_press <= 1 and long_held <= 1.
  - Else: lcnt holds (saturates). No further long_press for the same press.
- Long-press timing: debounced rise at edge D → long_press high in the cycle after edge D+LONG_CYCLES. One pulse per press.
- Release and long press at the same edge: if db falls at the same edge lcnt reaches LONG_CYCLES, long_press and release_pulse both fire that cycle. long_held clears on the next edge.
- Release before LONG_CYCLES: lcnt clears; no long_press.
- No arithmetic overflow: cnt never exceeds HOLD_CYCLES-1; lcnt saturates at LONG_CYCLES.
- Compatibility: with CHANNELS=2, CNT_WIDTH=10, HOLD_CYCLES=1023, level_out[1:0] replaces begin_transmit/begin_process. Unlike inline counters, release is also debounced.

Test Plan (CHANNELS=2, HOLD_CYCLES=4, LONG_CYCLES=10 unless stated):
- Reset: assert reset asynchronously mid-cycle with btn_in=2'b11 and counts in progress → all outputs 0 immediately. After deassert, level_out rises exactly 5 edges after the first sampling edge.
- Clean press then release on ch0:
  - btn_in[0] 0->1 held 20 cycles, then 0 → level_out[0] rises at E0+5, with press_pulse[0] high one cycle.
  - After the release, level_out[0] falls 5 edges after the 0 is first sampled, with release_pulse[0] high one cycle.
- Bounce rejection: btn_in[0] pattern 1,1,1,0,1,1,1,0 repeated 30 cycles → level_out[0] stays 0, no pulses. Then steady 1 → rises 5 edges later.
- Long press: ch1 held 30 cycles → long_press[1] single pulse at exactly 10 cycles after press_pulse[1]. long_held[1] is 1 until release. Releasing 8 cycles after press_pulse instead → no long_press.
- Independence/simultaneity: ch0 pressed while ch1 released on the same edge → press_pulse[0] and release_pulse[1] in the same cycle; neither disturbs the other's counters.
- Boundary HOLD_CYCLES=1: single-cycle 1 glitch → level_out follows for at least one cycle (2-edge latency), each change with exactly one pulse. Confirms no off-by-one at the minimum setting.
